game_flow_controller: RTL
=========================

// Module: game_flow_controller
// PURPOSE
//  Match-level sequencer for Pong. Decides when the ball/paddle datapath may move:
//  idle -> serve countdown -> play -> point hold -> serve ... -> game over.
//  Owns both score counters and the serve side, and handles pause.
//  Sits between the board buttons/keypads and img_generator's ball/paddle logic.
//  It replaces img_generator's local pause register and its in-line score counters.
// PARAMETERS
//  SCORE_W            3    width of each score counter
//  WIN_SCORE          7    score that ends the match; must be <= 2**SCORE_W-1
//  SERVE_DELAY_FRAMES 60   frame_tick pulses counted in SERVE before the ball launches
//  POINT_HOLD_FRAMES  30   frame_tick pulses the datapath stays frozen after a point
//  CNT_W              8    frame counter width; both delays must be < 2**CNT_W
// PORTS
//  CLOCK_25     in   1        25 MHz system clock
//  reset        in   1        asynchronous, active-high reset
//  frame_tick   in   1        one-cycle pulse per game step (BALL_CLOCK rate), CLOCK_25 domain
//  start_btn    in   1        raw level, asynchronous to CLOCK_25, 1 = pressed
//  pause_btn    in   1        raw level, asynchronous to CLOCK_25, 1 = pressed
//  miss_left    in   1        one-cycle pulse: ball passed player 1 (player 2 scores)
//  miss_right   in   1        one-cycle pulse: ball passed player 2 (player 1 scores)
//  run_enable   out  1        1 = ball/paddle datapath may update on frame_tick
//  serve_req    out  1        one-cycle pulse: datapath reloads the ball at the serve paddle
//  serve_side   out  1        0 = serve from player 1 paddle, 1 = from player 2
//  score_1      out  SCORE_W  player 1 score
//  score_2      out  SCORE_W  player 2 score
//  game_over    out  1        1 while in GAME_OVER
//  winner       out  1        0 = player 1, 1 = player 2; valid while game_over=1
//  state_out    out  3        current state encoding, for debug LEDs
// BEHAVIOUR
//  Reset values (async): state=IDLE, run_enable=0, serve_req=0, serve_side=0, score_1=0,
//   score_2=0, game_over=0, winner=0, frame counter=0, button sync/edge flops=0.
//  Buttons: 2-flop synchroniser + rising-edge detect.
//   A press is acted on at the 3rd CLOCK_25 edge after the pin rises.
//   A held button yields exactly one event.
//  States: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5. 6/7 -> IDLE next cycle.
//  IDLE: start edge -> SERVE, serve_side<=0, counter<=0.
//  SERVE: each frame_tick increments the counter.
//   When the counter reaches SERVE_DELAY_FRAMES-1 and a frame_tick occurs:
//   serve_req=1 for that one cycle (registered), state->PLAY, counter<=0.
//  PLAY: miss_right -> score_1+1; miss_left -> score_2+1; both update on the next edge.
//   The conceding side becomes serve_side.
//   Next state is GAME_OVER if the new score == WIN_SCORE, else POINT.
//   miss_left and miss_right in the same cycle: no score change, serve_side<=0, state->POINT.
//   pause edge -> PAUSED; miss has priority over pause in the same cycle.
//  POINT: counts POINT_HOLD_FRAMES frame_ticks, then -> SERVE, counter<=0.
//  PAUSED: pause edge -> PLAY with no serve_req and no score change.
//  GAME_OVER: game_over=1, winner=scorer of the final point, scores held.
//   start edge -> scores<=0, serve_side<=loser, state->SERVE.
//  Ignored inputs:
//   miss pulses outside PLAY;
//   pause edges outside PLAY/PAUSED;
//   start edges outside IDLE/GAME_OVER.
//  run_enable is a registered decode: it is 1 exactly in the cycles where state==PLAY.
//  Score arithmetic is SCORE_W unsigned. It never wraps, because WIN_SCORE terminates first.
//  Reset asserted mid-point or mid-pause returns to IDLE at once; there is no partial state.
// STRUCTURE
//  global_symbols.vh gains:
//   state encodings GFC_IDLE..GFC_GAME_OVER;
//   default WIN_SCORE, SERVE_DELAY_FRAMES and POINT_HOLD_FRAMES macros.
//  Sub-module button_edge (sync + rising-edge, 1-bit), instantiated twice.
//  The FSM, frame counter and score registers stay in this module.
// TESTING
//  1 reset, start pulse, 60 frame_ticks -> serve_req 1 cycle after tick 60;
//    run_enable=1 next cycle; serve_side=0.
//  2 PLAY, miss_right -> score_1=1, run_enable=0, POINT.
//    After 30 ticks SERVE with serve_side=1; after 60 more ticks serve_req.
//  3 score_2=6, miss_left -> score_2=7, game_over=1, winner=1.
//    Start -> scores 0, serve_side=0, SERVE.
//  4 PLAY, pause held 100 cycles -> one PAUSED entry; further misses ignored.
//    2nd press -> PLAY, no serve_req.
//  5 miss_left & miss_right same cycle -> scores unchanged, POINT, serve_side=0.
//    Pause + miss same cycle -> POINT.
//  6 reset pulse during POINT and during PAUSED -> all outputs at reset values same cycle.
//    Start works normally afterwards.

Source files
------------

// File: rtl/game_flow_controller_pkg.sv
// -----------------------------------------------------------------------------
// game_flow_controller_pkg
// Shared symbols for the Pong match sequencer: state encodings (also driven
// onto the debug LEDs) and the default match timing/scoring constants.
// -----------------------------------------------------------------------------
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        GFC_IDLE      = 3'd0,
        GFC_SERVE     = 3'd1,
        GFC_PLAY      = 3'd2,
        GFC_POINT     = 3'd3,
        GFC_PAUSED    = 3'd4,
        GFC_GAME_OVER = 3'd5
    } gfc_state_t;

    localparam int DEFAULT_SCORE_W            = 3;
    localparam int DEFAULT_WIN_SCORE          = 7;
    localparam int DEFAULT_SERVE_DELAY_FRAMES = 60;
    localparam int DEFAULT_POINT_HOLD_FRAMES  = 30;
    localparam int DEFAULT_CNT_W              = 8;

    // serve_side / winner encoding
    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

endpackage

// File: rtl/game_flow_controller_button_edge.sv
// -----------------------------------------------------------------------------
// button_edge
// Brings one raw, asynchronous push-button level into the CLOCK_25 domain and
// emits a single-cycle pulse on its rising edge. A held button gives exactly
// one pulse. The pulse is visible after the 2nd edge following the pin rise,
// so the consumer acts on it at the 3rd edge.
// Ports:
//   CLOCK_25  in  system clock
//   reset     in  asynchronous active-high reset
//   btn       in  raw button level, 1 = pressed
//   btn_edge  out one-cycle pulse on press
// -----------------------------------------------------------------------------
module button_edge (
    input  logic CLOCK_25,
    input  logic reset,
    input  logic btn,
    output logic btn_edge
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // NOTE: non-blocking assignments let each flop capture its neighbour's
    // pre-edge value, which is what makes this a shift chain rather than a wire.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= btn;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign btn_edge = sync_2 & ~sync_prev;

endmodule

// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
// Match-level sequencer for Pong: idle -> serve countdown -> play -> point
// hold -> serve ... -> game over. Owns both scores, the serve side and pause,
// and tells the ball/paddle datapath when it may move.
// Ports:
//   CLOCK_25    in   25 MHz system clock
//   reset       in   asynchronous active-high reset
//   frame_tick  in   one pulse per game step
//   start_btn   in   raw start button level
//   pause_btn   in   raw pause button level
//   miss_left   in   pulse: ball passed player 1 (player 2 scores)
//   miss_right  in   pulse: ball passed player 2 (player 1 scores)
//   run_enable  out  datapath may update (high exactly while in PLAY)
//   serve_req   out  pulse: reload the ball at the serving paddle
//   serve_side  out  0 = player 1 serves, 1 = player 2 serves
//   score_1/2   out  player scores
//   game_over   out  high while in GAME_OVER
//   winner      out  0 = player 1, 1 = player 2 (valid with game_over)
//   state_out   out  state encoding for debug LEDs
// -----------------------------------------------------------------------------
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int SCORE_W            = DEFAULT_SCORE_W,
    parameter int WIN_SCORE          = DEFAULT_WIN_SCORE,
    parameter int SERVE_DELAY_FRAMES = DEFAULT_SERVE_DELAY_FRAMES,
    parameter int POINT_HOLD_FRAMES  = DEFAULT_POINT_HOLD_FRAMES,
    parameter int CNT_W              = DEFAULT_CNT_W
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               run_enable,
    output logic               serve_req,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_out
);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(POINT_HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);

    gfc_state_t         state;
    logic [CNT_W-1:0]   frame_cnt;
    logic               start_edge;
    logic               pause_edge;
    logic [SCORE_W-1:0] score_1_inc;
    logic [SCORE_W-1:0] score_2_inc;

    button_edge u_start_edge (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .btn      (start_btn),
        .btn_edge (start_edge)
    );

    button_edge u_pause_edge (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .btn      (pause_btn),
        .btn_edge (pause_edge)
    );

    // Cannot wrap: reaching WIN_SCORE leaves PLAY before another increment.
    assign score_1_inc = score_1 + SCORE_W'(1);
    assign score_2_inc = score_2 + SCORE_W'(1);
    assign state_out   = state;

    // run_enable and game_over are set on every transition into/out of PLAY
    // and GAME_OVER so they track the state register cycle-for-cycle.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state      <= GFC_IDLE;
            frame_cnt  <= '0;
            run_enable <= 1'b0;
            serve_req  <= 1'b0;
            serve_side <= SIDE_P1;
            score_1    <= '0;
            score_2    <= '0;
            game_over  <= 1'b0;
            winner     <= SIDE_P1;
        end else begin
            serve_req <= 1'b0;
            case (state)
                GFC_IDLE: begin
                    if (start_edge) begin
                        state      <= GFC_SERVE;
                        serve_side <= SIDE_P1;
                        frame_cnt  <= '0;
                    end
                end

                GFC_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state      <= GFC_PLAY;
                            serve_req  <= 1'b1;
                            run_enable <= 1'b1;
                            frame_cnt  <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                GFC_PLAY: begin
                    // A miss outranks a simultaneous pause press.
                    if (miss_left && miss_right) begin
                        state      <= GFC_POINT;
                        run_enable <= 1'b0;
                        serve_side <= SIDE_P1;
                        frame_cnt  <= '0;
                    end else if (miss_right) begin
                        score_1    <= score_1_inc;
                        serve_side <= SIDE_P2;
                        run_enable <= 1'b0;
                        frame_cnt  <= '0;
                        if (score_1_inc == WIN_VALUE) begin
                            state     <= GFC_GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= SIDE_P1;
                        end else begin
                            state <= GFC_POINT;
                        end
                    end else if (miss_left) begin
                        score_2    <= score_2_inc;
                        serve_side <= SIDE_P1;
                        run_enable <= 1'b0;
                        frame_cnt  <= '0;
                        if (score_2_inc == WIN_VALUE) begin
                            state     <= GFC_GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= SIDE_P2;
                        end else begin
                            state <= GFC_POINT;
                        end
                    end else if (pause_edge) begin
                        state      <= GFC_PAUSED;
                        run_enable <= 1'b0;
                    end
                end

                GFC_POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == HOLD_LAST) begin
                            state     <= GFC_SERVE;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                GFC_PAUSED: begin
                    if (pause_edge) begin
                        state      <= GFC_PLAY;
                        run_enable <= 1'b1;
                    end
                end

                GFC_GAME_OVER: begin
                    if (start_edge) begin
                        state      <= GFC_SERVE;
                        score_1    <= '0;
                        score_2    <= '0;
                        serve_side <= ~winner;
                        game_over  <= 1'b0;
                        frame_cnt  <= '0;
                    end
                end

                default: begin
                    // Unused encodings 6/7 recover to IDLE.
                    state      <= GFC_IDLE;
                    run_enable <= 1'b0;
                    game_over  <= 1'b0;
                    frame_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
